// File: rtl/div_seq_if.sv
// div_seq_if: decode/execute handshake bundle for the divide sequencer.
// The master side drives the operation and consumes the result; the slave is div_seq.
interface div_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  div_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   modport master (
      output in_valid, div_op, src1, src2, flush, out_ready,
      input  in_ready, busy, out_valid, result
   );

   modport slave (
      input  in_valid, div_op, src1, src2, flush, out_ready,
      output in_ready, busy, out_valid, result
   );
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative 32-step restoring divider for div.w/div.wu/mod.w/mod.wu with sign fix-up.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and goes straight to DONE.
module div_seq (
   input  logic     clk,
   input  logic     reset,
   div_seq_if.slave div_bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_dvd;
   logic [31:0] r_dsr;
   logic [31:0] r_quo;
   logic [31:0] r_result;
   logic        r_want_q;
   logic        r_q_neg;
   logic        r_r_neg;

   logic        w_accept;
   logic        w_signed;
   logic [31:0] w_abs1;
   logic [31:0] w_abs2;
   logic [32:0] w_shift;
   logic [31:0] w_trial;
   logic        w_borrow;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_final;

   assign w_signed = div_bus.div_op[1];
   assign w_accept = div_bus.in_valid & div_bus.div_op[0] & (r_state == StIdle) & ~div_bus.flush;

   // Unsigned magnitude; 0x80000000 maps to itself, which is correct as an unsigned value.
   assign w_abs1 = (w_signed & div_bus.src1[31]) ? (32'd0 - div_bus.src1) : div_bus.src1;
   assign w_abs2 = (w_signed & div_bus.src2[31]) ? (32'd0 - div_bus.src2) : div_bus.src2;

   // One restoring step: bring in the next dividend bit and try to subtract.
   assign w_shift   = {r_rem, r_dvd[31]};
   assign w_borrow  = (w_shift < {1'b0, r_dsr});
   assign w_trial   = w_shift[31:0] - r_dsr;
   assign w_rem_nxt = w_borrow ? w_shift[31:0] : w_trial;
   assign w_quo_nxt = {r_quo[30:0], ~w_borrow};

   assign w_quo_fix = r_q_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt;
   assign w_rem_fix = r_r_neg ? (32'd0 - w_rem_nxt) : w_rem_nxt;
   assign w_final   = r_want_q ? w_quo_fix : w_rem_fix;

`ifdef DIV_ZERO_FAST_EN
   logic        w_zero_div;
   logic [31:0] w_zero_res;

   // Same values the full iteration produces: quotient all-ones (sign-fixed), remainder = src1.
   assign w_zero_div = (div_bus.src2 == 32'd0);
   assign w_zero_res = div_bus.div_op[2] ?
                       ((w_signed & div_bus.src1[31]) ? 32'd1 : 32'hFFFF_FFFF) : div_bus.src1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_quo    <= '0;
         r_result <= '0;
         r_want_q <= 1'b0;
         r_q_neg  <= 1'b0;
         r_r_neg  <= 1'b0;
      end else if (div_bus.flush) begin
         r_state  <= StIdle;
         r_result <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_want_q <= div_bus.div_op[2];
                  r_q_neg  <= w_signed & (div_bus.src1[31] ^ div_bus.src2[31]);
                  r_r_neg  <= w_signed & div_bus.src1[31];
                  r_dvd    <= w_abs1;
                  r_dsr    <= w_abs2;
                  r_rem    <= '0;
                  r_quo    <= '0;
                  r_cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
                  if (w_zero_div) begin
                     r_state  <= StDone;
                     r_result <= w_zero_res;
                  end else begin
                     r_state <= StCalc;
                  end
`else
                  r_state <= StCalc;
`endif
               end
            end
            StCalc: begin
               r_rem <= w_rem_nxt;
               r_dvd <= {r_dvd[30:0], 1'b0};
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state  <= StDone;
                  r_result <= w_final;
               end
            end
            StDone: begin
               if (div_bus.out_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign div_bus.in_ready  = (r_state == StIdle);
   assign div_bus.busy      = (r_state != StIdle);
   assign div_bus.out_valid = (r_state == StDone);
   assign div_bus.result    = r_result;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: random and directed divide operations checked against a plain-arithmetic model.
// Expected latency follows DIV_ZERO_FAST_EN when the bench is built with it.
module tb_div_seq;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   div_seq_if bus ();

   div_seq u_dut (
      .clk     (clk),
      .reset   (reset),
      .div_bus (bus.slave)
   );

`ifdef DIV_ZERO_FAST_EN
   localparam bit FastZero = 1'b1;
`else
   localparam bit FastZero = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: C-style truncating division; zero divisor gives all-ones quotient, remainder = dividend.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         q = (op[1] && a[31]) ? 64'd1 : 64'h0000_0000_FFFF_FFFF;
         r = longint'({32'd0, a});
      end else begin
         if (op[1]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         q = sa / sb;
         r = sa % sb;
      end
      return op[2] ? q[31:0] : r[31:0];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check_eq({tag, " ready timeout"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.div_op   = op;
      bus.src1     = a;
      bus.src2     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      // Scramble operands so any late sampling shows up as a wrong result.
      bus.div_op   = 3'($urandom);
      bus.src1     = $urandom;
      bus.src2     = $urandom;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp;
      logic [31:0] held;
      int          lat;
      int          exp_lat;
      bit          bad;
      exp     = model(op, a, b);
      exp_lat = (FastZero && b == 32'd0) ? 1 : 33;
      wait_ready(tag);
      accept(op, a, b);
      lat = 1;
      bad = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, " busy while calc"}, 32'(bad), 32'd0);
      check_eq({tag, " result"}, bus.result, exp);
      held = bus.result;
      bad  = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
      end
      if (hold > 0) check_eq({tag, " stall hold"}, 32'(bad), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_eq({tag, " after handshake"},
               32'({bus.in_ready, bus.busy, bus.out_valid}), 32'(3'b100));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      logic [2:0] op;
      bus.in_valid  = 1'b0;
      bus.div_op    = 3'd0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("reset flags", 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'(3'b100));
      check_eq("reset result", bus.result, 32'd0);

      run_op("udiv 100/7", 3'b101, 32'd100, 32'd7, 0);
      run_op("umod 100/7", 3'b001, 32'd100, 32'd7, 0);
      run_op("sdiv -7/2", 3'b111, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("smod -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("ovf div", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("ovf mod", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div0 q", 3'b101, 32'h1234_5678, 32'd0, 0);
      run_op("div0 r", 3'b001, 32'h1234_5678, 32'd0, 0);
      run_op("sdiv0 neg", 3'b111, 32'hFFFF_FF00, 32'd0, 0);
      run_op("backpressure", 3'b111, 32'd1000, 32'hFFFF_FFFD, 5);

      // Flush mid-calc at T+10, then a clean accept at T+11.
      accept(3'b101, 32'd5000, 32'd3);
      seen = 1'b0;
      repeat (9) begin
         if (bus.out_valid === 1'b1) seen = 1'b1;
         @(posedge clk); #1;
      end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check_eq("flush calc no valid", 32'(seen | bus.out_valid), 32'd0);
      check_eq("flush calc idle", 32'({bus.in_ready, bus.busy}), 32'(2'b10));
      run_op("post flush", 3'b111, 32'hFFFF_8000, 32'd7, 0);

      // Flush while the result waits in DONE.
      accept(3'b001, 32'd77, 32'd10);
      for (int i = 0; i < 60 && bus.out_valid !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check_eq("flush done", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));

      // Flush together with in_valid, and a non-divide op: neither is accepted.
      bus.flush = 1'b1;
      accept(3'b101, 32'd9, 32'd3);
      bus.flush = 1'b0;
      check_eq("flush blocks accept", 32'({bus.in_ready, bus.busy}), 32'(2'b10));
      accept(3'b110, 32'd9, 32'd3);
      check_eq("non-div ignored", 32'({bus.in_ready, bus.busy}), 32'(2'b10));

      // Reset mid-calc leaves nothing behind.
      accept(3'b111, 32'd12345, 32'd6);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("reset mid flags", 32'({bus.in_ready, bus.busy, bus.out_valid}), 32'(3'b100));
      check_eq("reset mid result", bus.result, 32'd0);

      for (int k = 0; k < 40; k++) begin
         op = {1'($urandom), 1'($urandom), 1'b1};
         run_op($sformatf("rand%0d", k), op, pick(), pick(), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
